// File: rtl/decode_stage_vr_pkg.sv
// Shared types and field positions for the decode stage: instruction field layout,
// control bundle and the field-splitting helper.
package decode_stage_vr_pkg;

  localparam int unsigned REG_IDX_W = 5;

  localparam int unsigned OP_LSB  = 0;
  localparam int unsigned OP_MSB  = 2;
  localparam int unsigned F3_LSB  = 3;
  localparam int unsigned F3_MSB  = 5;
  localparam int unsigned RD_LSB  = 6;
  localparam int unsigned RD_MSB  = 10;
  localparam int unsigned RS1_LSB = 11;
  localparam int unsigned RS1_MSB = 15;
  localparam int unsigned RS2_LSB = 16;
  localparam int unsigned RS2_MSB = 20;
  localparam int unsigned F11_LSB = 21;
  localparam int unsigned F11_MSB = 31;
  localparam int unsigned IMM_LSB = 6;

  typedef enum logic [2:0] {
    OpAlu, OpAluImm, OpLoad, OpStore, OpBranch, OpJal, OpJalr, OpAuipc
  } opcode_e;

  typedef struct packed {
    logic [2:0]           op;
    logic [2:0]           func3;
    logic [10:0]          func11;
    logic [REG_IDX_W-1:0] rd;
    logic [REG_IDX_W-1:0] rs1;
    logic [REG_IDX_W-1:0] rs2;
  } fields_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       mem_read;
    logic       jump;
    logic       jump_cond;
    logic [2:0] jump_cond_type;
    logic [3:0] alu_control;
    logic       alu_src_op1;
    logic       alu_src_op2;
    logic       pc_target_src;
    logic [1:0] result_src;
  } de_ctrl_t;

  function automatic fields_t decode_fields(input logic [31:0] instr);
    fields_t f;
    f.op     = instr[OP_MSB:OP_LSB];
    f.func3  = instr[F3_MSB:F3_LSB];
    f.func11 = instr[F11_MSB:F11_LSB];
    f.rd     = instr[RD_MSB:RD_LSB];
    f.rs1    = instr[RS1_MSB:RS1_LSB];
    f.rs2    = instr[RS2_MSB:RS2_LSB];
    return f;
  endfunction

endpackage

// File: rtl/decode_stage_vr_if.sv
// Fetch, writeback and execute-side signals of the decode stage.
interface decode_stage_vr_if
  import decode_stage_vr_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) ();
  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          in_instr;
  logic [XLEN-1:0]      in_pc;
  logic [XLEN-1:0]      in_pc_plus4;
  logic                 wb_we;
  logic [REG_IDX_W-1:0] wb_rd;
  logic [XLEN-1:0]      wb_result;
  logic                 ex_valid;
  logic                 ex_ready;
  logic [31:0]          ex_instr;
  logic                 ex_reg_write;
  logic                 ex_mem_write;
  logic                 ex_mem_read;
  logic                 ex_jump;
  logic                 ex_jump_cond;
  logic [2:0]           ex_jump_cond_type;
  logic [3:0]           ex_alu_control;
  logic                 ex_alu_src_op1;
  logic                 ex_alu_src_op2;
  logic                 ex_pc_target_src;
  logic [1:0]           ex_result_src;
  logic [XLEN-1:0]      ex_pc;
  logic [XLEN-1:0]      ex_pc_plus_4;
  logic [XLEN-1:0]      ex_imm_ext;
  logic [XLEN-1:0]      ex_rd1;
  logic [XLEN-1:0]      ex_rd2;
  logic [REG_IDX_W-1:0] ex_rd;
  logic [REG_IDX_W-1:0] ex_rs1;
  logic [REG_IDX_W-1:0] ex_rs2;
  logic [REG_IDX_W-1:0] de_rs1;
  logic [REG_IDX_W-1:0] de_rs2;
  logic [CNT_W-1:0]     stall_cycles;

  modport master (
    output flush, in_valid, in_instr, in_pc, in_pc_plus4, wb_we, wb_rd, wb_result, ex_ready,
    input  in_ready, ex_valid, ex_instr, ex_reg_write, ex_mem_write, ex_mem_read, ex_jump,
           ex_jump_cond, ex_jump_cond_type, ex_alu_control, ex_alu_src_op1, ex_alu_src_op2,
           ex_pc_target_src, ex_result_src, ex_pc, ex_pc_plus_4, ex_imm_ext, ex_rd1, ex_rd2,
           ex_rd, ex_rs1, ex_rs2, de_rs1, de_rs2, stall_cycles
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc, in_pc_plus4, wb_we, wb_rd, wb_result, ex_ready,
    output in_ready, ex_valid, ex_instr, ex_reg_write, ex_mem_write, ex_mem_read, ex_jump,
           ex_jump_cond, ex_jump_cond_type, ex_alu_control, ex_alu_src_op1, ex_alu_src_op2,
           ex_pc_target_src, ex_result_src, ex_pc, ex_pc_plus_4, ex_imm_ext, ex_rd1, ex_rd2,
           ex_rd, ex_rs1, ex_rs2, de_rs1, de_rs2, stall_cycles
  );
endinterface

// File: rtl/control_unit.sv
// Main decoder: opcode/func fields to the execute-stage control bundle.
module control_unit
  import decode_stage_vr_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [2:0]  func3,
  input  logic [10:0] func11,
  output de_ctrl_t    ctrl
);
  always_comb begin
    ctrl = '0;
    unique case (opcode_e'(op))
      OpAlu: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_control = {func11 == 11'h400, func3};
      end
      OpAluImm: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_src_op2 = 1'b1;
        ctrl.alu_control = {1'b0, func3};
      end
      OpLoad: begin
        ctrl.reg_write   = 1'b1;
        ctrl.mem_read    = 1'b1;
        ctrl.alu_src_op2 = 1'b1;
        ctrl.result_src  = 2'd1;
      end
      OpStore: begin
        ctrl.mem_write   = 1'b1;
        ctrl.alu_src_op2 = 1'b1;
      end
      OpBranch: begin
        ctrl.jump_cond      = 1'b1;
        ctrl.jump_cond_type = func3;
        ctrl.alu_control    = 4'b1000;
      end
      OpJal: begin
        ctrl.reg_write  = 1'b1;
        ctrl.jump       = 1'b1;
        ctrl.result_src = 2'd2;
      end
      OpJalr: begin
        ctrl.reg_write     = 1'b1;
        ctrl.jump          = 1'b1;
        ctrl.result_src    = 2'd2;
        ctrl.pc_target_src = 1'b1;
        ctrl.alu_src_op2   = 1'b1;
      end
      OpAuipc: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_src_op1 = 1'b1;
        ctrl.alu_src_op2 = 1'b1;
      end
    endcase
  end
endmodule

// File: rtl/imm_extend.sv
// Sign-extends the 26-bit immediate field to the datapath width.
module imm_extend #(
  parameter int unsigned XLEN = 32
) (
  input  logic [25:0]     imm_in,
  output logic [XLEN-1:0] imm_ext
);
  assign imm_ext = XLEN'($signed(imm_in));
endmodule

// File: rtl/regfile_bypass.sv
// Integer register file, two read ports, one write port with same-cycle write-through.
module regfile_bypass
  import decode_stage_vr_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [REG_IDX_W-1:0] wa,
  input  logic [XLEN-1:0]      wd,
  input  logic [REG_IDX_W-1:0] ra1,
  input  logic [REG_IDX_W-1:0] ra2,
  output logic [XLEN-1:0]      rd1,
  output logic [XLEN-1:0]      rd2
);
  localparam int unsigned IW = (NREG > 1) ? $clog2(NREG) : 1;

  logic [XLEN-1:0] regs_q [NREG];
  logic            wr_en;

  // x0 and indices beyond NREG are not architectural: they read 0 and swallow writes.
  function automatic logic live(input logic [REG_IDX_W-1:0] idx);
    return (idx != '0) && (32'(idx) < NREG);
  endfunction

  assign wr_en = we && live(wa);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREG); i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[wa[IW-1:0]] <= wd;
    end
  end

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (live(ra1)) rd1 = (wr_en && wa == ra1) ? wd : regs_q[ra1[IW-1:0]];
    if (live(ra2)) rd2 = (wr_en && wa == ra2) ? wd : regs_q[ra2[IW-1:0]];
  end
endmodule

// File: rtl/decode_stage_vr.sv
// Decode stage with valid/ready handshake: register read, control decode and a 1- or
// 2-entry FIFO toward execute whose held operands track writeback.
module decode_stage_vr
  import decode_stage_vr_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREG  = 32,
  parameter int unsigned SKID  = 1,
  parameter int unsigned CNT_W = 16
) (
  input logic              clk,
  input logic              rst_n,
  decode_stage_vr_if.slave bus
);
  typedef struct packed {
    de_ctrl_t             ctrl;
    logic [31:0]          instr;
    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      pc_plus_4;
    logic [XLEN-1:0]      imm_ext;
    logic [XLEN-1:0]      rd1;
    logic [XLEN-1:0]      rd2;
    logic [REG_IDX_W-1:0] rd;
    logic [REG_IDX_W-1:0] rs1;
    logic [REG_IDX_W-1:0] rs2;
  } entry_t;

  fields_t          fields;
  de_ctrl_t         ctrl;
  logic [XLEN-1:0]  imm_ext, rf_rd1, rf_rd2;
  entry_t           entry_new, out_q, out_d, skid_q, skid_d;
  logic             out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
  logic             in_ready, accept;
  logic [CNT_W-1:0] stall_q, stall_d;

  assign fields = decode_fields(bus.in_instr);

  control_unit u_ctrl (
    .op     (fields.op),
    .func3  (fields.func3),
    .func11 (fields.func11),
    .ctrl   (ctrl)
  );

  imm_extend #(.XLEN(XLEN)) u_imm (
    .imm_in  (bus.in_instr[31:IMM_LSB]),
    .imm_ext (imm_ext)
  );

  regfile_bypass #(.XLEN(XLEN), .NREG(NREG)) u_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (bus.wb_we),
    .wa    (bus.wb_rd),
    .wd    (bus.wb_result),
    .ra1   (fields.rs1),
    .ra2   (fields.rs2),
    .rd1   (rf_rd1),
    .rd2   (rf_rd2)
  );

  // Keeps a held entry's operands equal to what the register file would now return.
  function automatic entry_t snoop(input entry_t e);
    entry_t r = e;
    if (bus.wb_we && bus.wb_rd != '0 && 32'(bus.wb_rd) < NREG) begin
      if (e.rs1 == bus.wb_rd) r.rd1 = bus.wb_result;
      if (e.rs2 == bus.wb_rd) r.rd2 = bus.wb_result;
    end
    return r;
  endfunction

  assign in_ready = (SKID != 0) ? ~skid_valid_q : (~out_valid_q | bus.ex_ready);
  assign accept   = bus.in_valid & in_ready & ~bus.flush;

  always_comb begin
    entry_new           = '0;
    entry_new.ctrl      = ctrl;
    entry_new.instr     = bus.in_instr;
    entry_new.pc        = bus.in_pc;
    entry_new.pc_plus_4 = bus.in_pc_plus4;
    entry_new.imm_ext   = imm_ext;
    entry_new.rd1       = rf_rd1;
    entry_new.rd2       = rf_rd2;
    entry_new.rd        = fields.rd;
    entry_new.rs1       = fields.rs1;
    entry_new.rs2       = fields.rs2;
  end

  always_comb begin
    out_d        = snoop(out_q);
    skid_d       = snoop(skid_q);
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (bus.flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || bus.ex_ready) begin
      if (skid_valid_q) begin
        out_d        = skid_d;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = accept;
        if (accept) out_d = entry_new;
      end
    end else if (accept && SKID != 0) begin
      skid_d       = entry_new;
      skid_valid_d = 1'b1;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (out_valid_q && !bus.ex_ready && stall_q != '1) stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      stall_q      <= '0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      stall_q      <= stall_d;
    end
  end

  assign bus.in_ready          = in_ready;
  assign bus.de_rs1            = fields.rs1;
  assign bus.de_rs2            = fields.rs2;
  assign bus.stall_cycles      = stall_q;
  assign bus.ex_valid          = out_valid_q;
  assign bus.ex_instr          = out_q.instr;
  assign bus.ex_reg_write      = out_q.ctrl.reg_write & out_valid_q;
  assign bus.ex_mem_write      = out_q.ctrl.mem_write & out_valid_q;
  assign bus.ex_mem_read       = out_q.ctrl.mem_read & out_valid_q;
  assign bus.ex_jump           = out_q.ctrl.jump & out_valid_q;
  assign bus.ex_jump_cond      = out_q.ctrl.jump_cond & out_valid_q;
  assign bus.ex_jump_cond_type = out_q.ctrl.jump_cond_type;
  assign bus.ex_alu_control    = out_q.ctrl.alu_control;
  assign bus.ex_alu_src_op1    = out_q.ctrl.alu_src_op1;
  assign bus.ex_alu_src_op2    = out_q.ctrl.alu_src_op2;
  assign bus.ex_pc_target_src  = out_q.ctrl.pc_target_src;
  assign bus.ex_result_src     = out_q.ctrl.result_src;
  assign bus.ex_pc             = out_q.pc;
  assign bus.ex_pc_plus_4      = out_q.pc_plus_4;
  assign bus.ex_imm_ext        = out_q.imm_ext;
  assign bus.ex_rd1            = out_q.rd1;
  assign bus.ex_rd2            = out_q.rd2;
  assign bus.ex_rd             = out_q.rd;
  assign bus.ex_rs1            = out_q.rs1;
  assign bus.ex_rs2            = out_q.rs2;
endmodule

// File: tb/tb_decode_stage_vr.sv
// Bench for decode_stage_vr: directed scenarios plus random traffic against a FIFO and
// architectural-register model.
module tb_decode_stage_vr;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREG  = 32;
  localparam int unsigned SKID  = 1;
  localparam int unsigned CNT_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  decode_stage_vr_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  decode_stage_vr #(.XLEN(XLEN), .NREG(NREG), .SKID(SKID), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
  } txn_t;

  txn_t            q[$];
  logic [XLEN-1:0] mreg [NREG];
  int unsigned     mstall;
  int              n_checks = 0;
  int              n_fail = 0;

  function automatic logic [31:0] mk_instr(input logic [2:0] op, input logic [2:0] f3,
                                           input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [4:0] rs2, input logic [10:0] f11);
    return {f11, rs2, rs1, rd, f3, op};
  endfunction

  // {reg_write, mem_write, mem_read, jump, jump_cond} per opcode
  function automatic logic [4:0] exp_ctrl(input logic [2:0] op);
    logic rw = (op != 3'd3) && (op != 3'd4);
    return {rw, op == 3'd3, op == 3'd2, (op == 3'd5) || (op == 3'd6), op == 3'd4};
  endfunction

  function automatic bit m_ready();
    if (SKID != 0) return q.size() < 2;
    return (q.size() == 0) || bus.ex_ready;
  endfunction

  function automatic void model_reset();
    q.delete();
    for (int i = 0; i < int'(NREG); i++) mreg[i] = '0;
    mstall = 0;
  endfunction

  task automatic offer(input logic v, input logic [31:0] instr, input logic [XLEN-1:0] pc);
    bus.in_valid    = v;
    bus.in_instr    = instr;
    bus.in_pc       = pc;
    bus.in_pc_plus4 = pc + 4;
  endtask

  task automatic set_wb(input logic we, input logic [4:0] rd, input logic [XLEN-1:0] res);
    bus.wb_we     = we;
    bus.wb_rd     = rd;
    bus.wb_result = res;
  endtask

  // One clock edge: advance the model from the current inputs, then settle for sampling.
  task automatic tick();
    int  sz;
    bit  acc;
    txn_t t;
    @(posedge clk);
    sz  = q.size();
    acc = bus.in_valid && m_ready() && !bus.flush;
    if (sz > 0 && !bus.ex_ready && mstall < (2 ** CNT_W) - 1) mstall++;
    if (bus.flush) q.delete();
    else begin
      if (sz > 0 && bus.ex_ready) void'(q.pop_front());
      if (acc) begin
        t.instr = bus.in_instr;
        t.pc    = bus.in_pc;
        t.pc4   = bus.in_pc_plus4;
        q.push_back(t);
      end
    end
    if (bus.wb_we && bus.wb_rd != 0 && 32'(bus.wb_rd) < NREG) mreg[bus.wb_rd] = bus.wb_result;
    #1;
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    bus.flush = 1'b0;
    bus.ex_ready = 1'b0;
    offer(1'b0, '0, '0);
    set_wb(1'b0, '0, '0);
    model_reset();
    @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.flush = 1'b0;
    bus.ex_ready = 1'b0;
    offer(1'b0, '0, '0);
    set_wb(1'b0, '0, '0);
    model_reset();
    #1;
    n_checks++; if (bus.ex_valid !== 1'b0) begin n_fail++;
      $display("FAIL reset_valid: got %b want 0", bus.ex_valid); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++;
      $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    n_checks++; if (bus.stall_cycles !== '0) begin n_fail++;
      $display("FAIL reset_stall: got %0d want 0", bus.stall_cycles); end
    n_checks++; if ({bus.ex_pc, bus.ex_rd1, bus.ex_instr} !== '0) begin n_fail++;
      $display("FAIL reset_bundle: pc %h rd1 %h instr %h want 0", bus.ex_pc, bus.ex_rd1,
               bus.ex_instr); end
    @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic test_add();
    bus.ex_ready = 1'b1;
    offer(1'b1, mk_instr(3'd0, 3'd0, 5'd7, 5'd1, 5'd2, 11'd0), 32'h100);
    tick();
    offer(1'b0, '0, '0);
    n_checks++; if (bus.ex_valid !== 1'b1) begin n_fail++;
      $display("FAIL add_valid: got %b want 1", bus.ex_valid); end
    n_checks++; if (bus.ex_pc !== 32'h100) begin n_fail++;
      $display("FAIL add_pc: got %h want 100", bus.ex_pc); end
    n_checks++; if (bus.ex_pc_plus_4 !== 32'h104) begin n_fail++;
      $display("FAIL add_pc4: got %h want 104", bus.ex_pc_plus_4); end
    n_checks++; if (bus.ex_rd !== 5'd7) begin n_fail++;
      $display("FAIL add_rd: got %0d want 7", bus.ex_rd); end
    n_checks++; if (bus.ex_reg_write !== 1'b1 || bus.ex_mem_write !== 1'b0) begin n_fail++;
      $display("FAIL add_ctrl: got rw %b mw %b want 1 0", bus.ex_reg_write, bus.ex_mem_write);
    end
    tick();
    n_checks++; if (bus.ex_valid !== 1'b0) begin n_fail++;
      $display("FAIL add_drain: got %b want 0", bus.ex_valid); end
  endtask

  task automatic test_bypass();
    bus.ex_ready = 1'b1;
    set_wb(1'b1, 5'd3, 32'hDEAD);
    offer(1'b1, mk_instr(3'd0, 3'd0, 5'd4, 5'd3, 5'd0, 11'd0), 32'h140);
    tick();
    set_wb(1'b1, 5'd0, 32'h55);
    offer(1'b1, mk_instr(3'd0, 3'd0, 5'd4, 5'd0, 5'd0, 11'd0), 32'h144);
    n_checks++; if (bus.ex_rd1 !== 32'hDEAD) begin n_fail++;
      $display("FAIL bypass_rd1: got %h want dead", bus.ex_rd1); end
    tick();
    set_wb(1'b0, '0, '0);
    offer(1'b1, mk_instr(3'd0, 3'd0, 5'd4, 5'd0, 5'd3, 11'd0), 32'h148);
    n_checks++; if (bus.ex_rd1 !== '0) begin n_fail++;
      $display("FAIL bypass_x0: got %h want 0", bus.ex_rd1); end
    tick();
    offer(1'b0, '0, '0);
    n_checks++; if (bus.ex_rd2 !== 32'hDEAD) begin n_fail++;
      $display("FAIL regfile_write: got %h want dead", bus.ex_rd2); end
    tick();
  endtask

  task automatic test_skid_order();
    apply_reset();
    bus.ex_ready = 1'b0;
    offer(1'b1, mk_instr(3'd0, 3'd1, 5'd1, 5'd0, 5'd0, 11'd0), 32'h200);
    tick();
    n_checks++; if (bus.ex_valid !== 1'b1 || bus.ex_pc !== 32'h200) begin n_fail++;
      $display("FAIL skid_first: got v %b pc %h want 1 200", bus.ex_valid, bus.ex_pc); end
    offer(1'b1, mk_instr(3'd0, 3'd2, 5'd2, 5'd0, 5'd0, 11'd0), 32'h204);
    tick();
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++;
      $display("FAIL skid_full_ready: got %b want 0", bus.in_ready); end
    offer(1'b1, mk_instr(3'd0, 3'd3, 5'd3, 5'd0, 5'd0, 11'd0), 32'h208);
    tick();
    tick();
    n_checks++; if (bus.stall_cycles !== 4'd3) begin n_fail++;
      $display("FAIL skid_stall: got %0d want 3", bus.stall_cycles); end
    n_checks++; if (bus.ex_pc !== 32'h200 || bus.in_ready !== 1'b0) begin n_fail++;
      $display("FAIL skid_hold: got pc %h rdy %b want 200 0", bus.ex_pc, bus.in_ready); end
    bus.ex_ready = 1'b1;
    tick();
    n_checks++; if (bus.ex_pc !== 32'h204 || bus.ex_valid !== 1'b1) begin n_fail++;
      $display("FAIL skid_order2: got pc %h v %b want 204 1", bus.ex_pc, bus.ex_valid); end
    n_checks++; if (bus.in_ready !== 1'b1 || bus.stall_cycles !== 4'd3) begin n_fail++;
      $display("FAIL skid_release: got rdy %b stall %0d want 1 3", bus.in_ready,
               bus.stall_cycles); end
    tick();
    offer(1'b0, '0, '0);
    n_checks++; if (bus.ex_pc !== 32'h208 || bus.ex_valid !== 1'b1) begin n_fail++;
      $display("FAIL skid_order3: got pc %h v %b want 208 1", bus.ex_pc, bus.ex_valid); end
    tick();
    n_checks++; if (bus.ex_valid !== 1'b0) begin n_fail++;
      $display("FAIL skid_empty: got %b want 0", bus.ex_valid); end
  endtask

  task automatic test_skid_snoop();
    bus.ex_ready = 1'b0;
    set_wb(1'b1, 5'd5, 32'h0BAD);
    offer(1'b1, mk_instr(3'd0, 3'd0, 5'd1, 5'd1, 5'd1, 11'd0), 32'h300);
    tick();
    set_wb(1'b0, '0, '0);
    offer(1'b1, mk_instr(3'd0, 3'd0, 5'd2, 5'd0, 5'd5, 11'd0), 32'h304);
    tick();
    offer(1'b0, '0, '0);
    set_wb(1'b1, 5'd5, 32'h1234);
    tick();
    set_wb(1'b0, '0, '0);
    bus.ex_ready = 1'b1;
    tick();
    n_checks++; if (bus.ex_pc !== 32'h304 || bus.ex_rd2 !== 32'h1234) begin n_fail++;
      $display("FAIL skid_snoop: got pc %h rd2 %h want 304 1234", bus.ex_pc, bus.ex_rd2); end
    tick();
  endtask

  task automatic test_flush();
    bus.ex_ready = 1'b0;
    offer(1'b1, mk_instr(3'd3, 3'd2, 5'd0, 5'd1, 5'd2, 11'd0), 32'h400);
    tick();
    offer(1'b1, mk_instr(3'd0, 3'd0, 5'd3, 5'd1, 5'd2, 11'd0), 32'h404);
    tick();
    n_checks++; if (bus.ex_mem_write !== 1'b1 || bus.in_ready !== 1'b0) begin n_fail++;
      $display("FAIL flush_pre: got mw %b rdy %b want 1 0", bus.ex_mem_write, bus.in_ready);
    end
    bus.flush = 1'b1;
    offer(1'b1, mk_instr(3'd0, 3'd0, 5'd9, 5'd0, 5'd0, 11'd0), 32'h900);
    tick();
    bus.flush = 1'b0;
    offer(1'b0, '0, '0);
    n_checks++; if (bus.ex_valid !== 1'b0 || bus.ex_mem_write !== 1'b0) begin n_fail++;
      $display("FAIL flush_out: got v %b mw %b want 0 0", bus.ex_valid, bus.ex_mem_write); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++;
      $display("FAIL flush_ready: got %b want 1", bus.in_ready); end
    bus.ex_ready = 1'b1;
    tick();
    n_checks++; if (bus.ex_valid !== 1'b0) begin n_fail++;
      $display("FAIL flush_skid_gone: got %b want 0", bus.ex_valid); end
    bus.flush = 1'b1;
    offer(1'b1, mk_instr(3'd0, 3'd0, 5'd9, 5'd0, 5'd0, 11'd0), 32'h908);
    tick();
    bus.flush = 1'b0;
    offer(1'b0, '0, '0);
    n_checks++; if (bus.ex_valid !== 1'b0) begin n_fail++;
      $display("FAIL flush_drop: got v %b pc %h want 0", bus.ex_valid, bus.ex_pc); end
  endtask

  task automatic test_async_reset();
    bus.ex_ready = 1'b0;
    offer(1'b1, mk_instr(3'd2, 3'd0, 5'd6, 5'd3, 5'd5, 11'd0), 32'h500);
    tick();
    tick();
    offer(1'b0, '0, '0);
    #4 rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++; if (bus.ex_valid !== 1'b0 || bus.stall_cycles !== '0) begin n_fail++;
      $display("FAIL async_reset: got v %b stall %0d want 0 0", bus.ex_valid,
               bus.stall_cycles); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++;
      $display("FAIL async_reset_ready: got %b want 1", bus.in_ready); end
    @(posedge clk);
    #3 rst_n = 1'b1;
    bus.ex_ready = 1'b1;
    offer(1'b1, mk_instr(3'd0, 3'd0, 5'd6, 5'd3, 5'd5, 11'd0), 32'h600);
    tick();
    offer(1'b0, '0, '0);
    n_checks++; if (bus.ex_rd1 !== '0 || bus.ex_rd2 !== '0) begin n_fail++;
      $display("FAIL async_reset_regs: got rd1 %h rd2 %h want 0 0", bus.ex_rd1, bus.ex_rd2);
    end
    tick();
  endtask

  task automatic test_random();
    txn_t            t;
    logic [XLEN-1:0] e_imm;
    logic [4:0]      e_ctrl;
    logic [4:0]      rs1, rs2;
    logic [4:0]      g_ctrl;
    for (int cyc = 0; cyc < 400; cyc++) begin
      bus.flush    = ($urandom_range(0, 15) == 0);
      bus.ex_ready = ($urandom_range(0, 2) != 0);
      set_wb($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
      offer($urandom_range(0, 3) != 0,
            mk_instr(3'($urandom_range(0, 7)), 3'($urandom), 5'($urandom),
                     5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                     ($urandom_range(0, 1) == 1) ? 11'h400 : 11'($urandom)),
            {$urandom} & ~32'h3);
      tick();
      g_ctrl = {bus.ex_reg_write, bus.ex_mem_write, bus.ex_mem_read, bus.ex_jump,
                bus.ex_jump_cond};
      n_checks++; if (bus.ex_valid !== (q.size() > 0)) begin n_fail++;
        $display("FAIL rnd_valid @%0d: got %b want %b", cyc, bus.ex_valid, q.size() > 0); end
      n_checks++; if (bus.in_ready !== m_ready()) begin n_fail++;
        $display("FAIL rnd_ready @%0d: got %b want %b", cyc, bus.in_ready, m_ready()); end
      n_checks++; if (bus.stall_cycles !== CNT_W'(mstall)) begin n_fail++;
        $display("FAIL rnd_stall @%0d: got %0d want %0d", cyc, bus.stall_cycles, mstall); end
      n_checks++; if (bus.de_rs1 !== bus.in_instr[15:11] || bus.de_rs2 !== bus.in_instr[20:16])
        begin n_fail++;
        $display("FAIL rnd_de_rs @%0d: got %0d %0d", cyc, bus.de_rs1, bus.de_rs2); end
      if (q.size() > 0) begin
        t      = q[0];
        rs1    = t.instr[15:11];
        rs2    = t.instr[20:16];
        e_imm  = XLEN'($signed(t.instr[31:6]));
        e_ctrl = exp_ctrl(t.instr[2:0]);
        n_checks++; if (bus.ex_instr !== t.instr || bus.ex_pc !== t.pc ||
                        bus.ex_pc_plus_4 !== t.pc4) begin n_fail++;
          $display("FAIL rnd_pc @%0d: got %h %h %h want %h %h %h", cyc, bus.ex_instr,
                   bus.ex_pc, bus.ex_pc_plus_4, t.instr, t.pc, t.pc4); end
        n_checks++; if (bus.ex_rd1 !== mreg[rs1] || bus.ex_rd2 !== mreg[rs2]) begin n_fail++;
          $display("FAIL rnd_operands @%0d: got %h %h want %h %h", cyc, bus.ex_rd1,
                   bus.ex_rd2, mreg[rs1], mreg[rs2]); end
        n_checks++; if (bus.ex_imm_ext !== e_imm) begin n_fail++;
          $display("FAIL rnd_imm @%0d: got %h want %h", cyc, bus.ex_imm_ext, e_imm); end
        n_checks++; if (bus.ex_rd !== t.instr[10:6] || bus.ex_rs1 !== rs1 ||
                        bus.ex_rs2 !== rs2) begin n_fail++;
          $display("FAIL rnd_idx @%0d: got %0d %0d %0d", cyc, bus.ex_rd, bus.ex_rs1,
                   bus.ex_rs2); end
        n_checks++; if (g_ctrl !== e_ctrl) begin n_fail++;
          $display("FAIL rnd_ctrl @%0d: got %b want %b", cyc, g_ctrl, e_ctrl); end
      end else begin
        n_checks++; if (g_ctrl !== 5'b0) begin n_fail++;
          $display("FAIL rnd_ctrl_idle @%0d: got %b want 00000", cyc, g_ctrl); end
      end
    end
    bus.flush = 1'b0;
    offer(1'b0, '0, '0);
    set_wb(1'b0, '0, '0);
  endtask

  initial begin
    test_reset();
    test_add();
    test_bypass();
    test_skid_order();
    test_skid_snoop();
    test_flush();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/decode_stage_vr.md
Name: decode_stage_vr

Overview:
- Parametrised decode stage with a valid/ready handshake. It replaces the stall/clear-driven ID/EX register.
- Contains the integer register file (posedge write with write-through bypass), the existing control_unit and imm_extend, and a 1- or 2-entry output buffer.
- Held entries snoop writeback so that buffered operands never go stale.
- Sits between fetch (upstream handshake) and execute (downstream handshake).

Parameters:
- XLEN, 32, datapath/PC width.
- NREG, 32, architectural registers (power of 2, 2..32). Indices >= NREG read 0; writes to them are dropped.
- SKID, 1. 0 gives a single output register with combinational in_ready. 1 adds a skid entry, which makes in_ready registered.
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  kill all buffered entries and any same-cycle acceptance
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage accepts this cycle
- in_instr  in  32  instruction word
- in_pc, in_pc_plus4  in  XLEN  fetch PC / PC+4
- wb_we  in  1  writeback enable
- wb_rd  in  5  writeback register index
- wb_result  in  XLEN  writeback data
- ex_valid  out  1  output entry valid
- ex_ready  in  1  execute accepts the output entry
- ex_instr  out  32  debug copy of the instruction
- ex_reg_write, ex_mem_write, ex_mem_read, ex_jump, ex_jump_cond  out  1 each  controls, ANDed with ex_valid
- ex_jump_cond_type  out  3  branch type
- ex_alu_control  out  4  ALU op
- ex_alu_src_op1, ex_alu_src_op2, ex_pc_target_src  out  1 each  mux selects
- ex_result_src  out  2  result select
- ex_pc, ex_pc_plus_4, ex_imm_ext, ex_rd1, ex_rd2  out  XLEN  datapath bundle
- ex_rd, ex_rs1, ex_rs2  out  5  register indices
- de_rs1, de_rs2  out  5  combinational rs fields of in_instr, for the hazard unit
- stall_cycles  out  CNT_W  saturating count of back-pressure cycles

Behaviour:
- Field decode:
  - rs1 = instr[15:11], rs2 = instr[20:16], rd = instr[10:6].
  - Control unit inputs: op = [2:0], func3 = [5:3], func11 = [31:21].
  - imm_extend input: instr[31:6].
- Reset (rst_n low, asynchronous):
  - ex_valid = 0, skid entry invalid, stall_cycles = 0.
  - All ex_* bundle fields = 0 and all registers = 0.
  - in_ready = 1 after reset.
- Register file:
  - x0 reads 0; writes to x0 are ignored.
  - Writes occur on posedge when wb_we = 1.
  - Read bypass: if wb_we and wb_rd == rs != 0, the read returns wb_result in the same cycle.
- Accept condition: in_valid & in_ready & ~flush. Latency from accept to ex_valid is 1 cycle.
- SKID = 0:
  - in_ready = ~ex_valid | ex_ready.
  - On accept, the output entry loads the decoded bundle.
  - If ex_ready drains the entry with no new accept, ex_valid goes to 0.
- SKID = 1:
  - in_ready = ~skid_valid (registered).
  - Accept with the output free or draining: the bundle goes to the output entry.
  - Accept with the output held (ex_valid & ~ex_ready): the bundle goes to the skid entry.
  - Output drains with the skid entry valid: skid moves to output the next cycle and skid_valid clears. A simultaneous new accept is impossible because in_ready = 0.
  - Ordering is strictly FIFO.
- Writeback snoop: every cycle, for each valid held entry (output and skid), if wb_we and wb_rd == entry.rs1 != 0 (resp. rs2), the entry's rd1 (resp. rd2) is overwritten with wb_result.
- Flush:
  - Next cycle ex_valid = 0 and skid_valid = 0.
  - The same-cycle in_valid instruction is dropped.
  - Flush overrides ex_ready and accept.
  - Datapath fields may hold stale values but the controls read 0.
- stall_cycles: increments each cycle ex_valid & ~ex_ready, saturates at 2^CNT_W - 1, and is cleared only by reset.
- Reset asserted mid-operation discards all entries immediately.

Decomposition:
- Package decode_pkg holds:
  - struct de_bundle_t (all ex_* fields plus rs1/rs2/rd);
  - REG_IDX_W = 5 and the instruction field bit-position constants;
  - the function decode_fields().
- Sub-module regfile_bypass (parametrised XLEN/NREG, async reset, write-through) is natural.
- control_unit and imm_extend are instantiated unchanged.

Test Plan:
- ADD-type instr at pc 0x100, ex_ready = 1 -> ex_valid = 1 one cycle later, ex_pc = 0x100, ex_rd = instr[10:6], ex_reg_write = 1.
- wb_we = 1, wb_rd = 3, wb_result = 0xDEAD in the same cycle as accepting an instr with rs1 = 3 -> ex_rd1 = 0xDEAD. With wb_rd = 0 and rs1 = 0 -> ex_rd1 = 0.
- SKID = 1 with ex_ready held 0 for 3 cycles while three instrs are offered -> the first is in output, the second in skid, in_ready = 0. The third is accepted only after release. Output order is 1, 2, 3. stall_cycles = 3.
- Second instr held in skid with rs2 = 5, then wb writes x5 = 0x1234 -> when presented, ex_rd2 = 0x1234.
- flush asserted with both entries full and in_valid = 1 -> next cycle ex_valid = 0, ex_mem_write = 0, in_ready = 1, and the dropped instruction never appears.
- rst_n pulsed low mid-stream (asynchronous, between edges) -> ex_valid = 0 immediately, stall_cycles = 0, registers read 0.
